// File: rtl/intel_vvp_icon_pkg.sv
// Shared types and helpers for the VVP icon AXI-Stream blocks.
package intel_vvp_icon_pkg;

  localparam int unsigned VVP_USER_KEEP_BITS = 2;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Token streams carry a single user bit; pixel streams carry byte-keep bits.
  function automatic int unsigned user_width(input int unsigned is_token,
                                             input int unsigned data_width);
    int unsigned keep_bits;
    keep_bits = (data_width + 7) / 8;
    if (is_token != 0) begin
      user_width = 1;
    end else if (keep_bits > VVP_USER_KEEP_BITS) begin
      user_width = keep_bits;
    end else begin
      user_width = VVP_USER_KEEP_BITS;
    end
  endfunction

endpackage

// File: rtl/intel_vvp_icon_axi_packet_arbiter_if.sv
// Bundled requester and merged AXI-Stream signals of the packet arbiter.
interface intel_vvp_icon_axi_packet_arbiter_if
  import intel_vvp_icon_pkg::*;
#(
  parameter int unsigned NUM_INPUTS         = 2,
  parameter int unsigned DATA_WIDTH         = 24,
  parameter int unsigned IS_TOKEN_INTERFACE = 0,
  parameter int unsigned USER_WIDTH         = user_width(IS_TOKEN_INTERFACE, DATA_WIDTH)
);

  logic [NUM_INPUTS-1:0]            axi_st_din_tvalid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] axi_st_din_tdata;
  logic [NUM_INPUTS*USER_WIDTH-1:0] axi_st_din_tuser;
  logic [NUM_INPUTS-1:0]            axi_st_din_tlast;
  logic [NUM_INPUTS-1:0]            axi_st_din_tready;

  logic                  axi_st_dout_tvalid;
  logic [DATA_WIDTH-1:0] axi_st_dout_tdata;
  logic [USER_WIDTH-1:0] axi_st_dout_tuser;
  logic                  axi_st_dout_tlast;
  logic                  axi_st_dout_tready;

  // master: the arbiter itself; slave: requesters plus downstream sink.
  modport master (
    input  axi_st_din_tvalid, axi_st_din_tdata, axi_st_din_tuser, axi_st_din_tlast,
    output axi_st_din_tready,
    output axi_st_dout_tvalid, axi_st_dout_tdata, axi_st_dout_tuser, axi_st_dout_tlast,
    input  axi_st_dout_tready
  );

  modport slave (
    output axi_st_din_tvalid, axi_st_din_tdata, axi_st_din_tuser, axi_st_din_tlast,
    input  axi_st_din_tready,
    input  axi_st_dout_tvalid, axi_st_dout_tdata, axi_st_dout_tuser, axi_st_dout_tlast,
    output axi_st_dout_tready
  );

endinterface

// File: rtl/intel_vvp_icon_axi_pipeline_stage.sv
// Single-entry AXI-Stream register slice; full throughput, stable while stalled.
module intel_vvp_icon_axi_pipeline_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/intel_vvp_icon_axi_packet_arbiter.sv
// Round-robin, packet-locked merge of NUM_INPUTS AXI-Stream requesters onto one
// registered output stream.
module intel_vvp_icon_axi_packet_arbiter
  import intel_vvp_icon_pkg::*;
#(
  parameter int unsigned NUM_INPUTS         = 2,
  parameter int unsigned DATA_WIDTH         = 24,
  parameter int unsigned IS_TOKEN_INTERFACE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_enable,
  intel_vvp_icon_axi_packet_arbiter_if.master axi,
  output logic [1:0] grant_id,
  output logic       busy
);

  localparam int unsigned USER_WIDTH = user_width(IS_TOKEN_INTERFACE, DATA_WIDTH);
  localparam int unsigned BeatW      = DATA_WIDTH + USER_WIDTH + 1;
  localparam int          NumIn      = int'(NUM_INPUTS);
  localparam logic [1:0]  LastIdx    = 2'(NUM_INPUTS - 1);

  arb_state_e state_q, state_d;
  // Holds the current owner while locked and the last owner while idle.
  logic [1:0] owner_q, owner_d;

  logic                  pick_found;
  logic [1:0]            pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  stage_in_valid;
  logic                  stage_in_ready;
  logic [BeatW-1:0]      stage_in_beat;
  logic [BeatW-1:0]      stage_out_beat;

  // Scan downward so the closest requester after the last owner wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = owner_q;
    for (int k = NumIn; k >= 1; k--) begin
      for (int j = 0; j < NumIn; j++) begin
        if (((int'(owner_q) + k) % NumIn) == j && axi.axi_st_din_tvalid[j]) begin
          pick_found = 1'b1;
          pick_idx   = 2'(j);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    for (int j = 0; j < NumIn; j++) begin
      if (owner_q == 2'(j)) begin
        sel_valid = axi.axi_st_din_tvalid[j];
        sel_last  = axi.axi_st_din_tlast[j];
        sel_data  = axi.axi_st_din_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        sel_user  = axi.axi_st_din_tuser[j*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  always_comb begin
    axi.axi_st_din_tready = '0;
    for (int j = 0; j < NumIn; j++) begin
      axi.axi_st_din_tready[j] = (state_q == StLocked) && (owner_q == 2'(j)) && stage_in_ready;
    end
  end

  assign stage_in_valid = (state_q == StLocked) && sel_valid;
  assign stage_in_beat  = {sel_last, sel_user, sel_data};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (arb_enable && pick_found) begin
          state_d = StLocked;
          owner_d = pick_idx;
        end
      end
      StLocked: begin
        if (sel_valid && stage_in_ready && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= LastIdx;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == StLocked);

  intel_vvp_icon_axi_pipeline_stage #(
    .WIDTH (BeatW)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (stage_in_valid),
    .in_ready  (stage_in_ready),
    .in_data   (stage_in_beat),
    .out_valid (axi.axi_st_dout_tvalid),
    .out_ready (axi.axi_st_dout_tready),
    .out_data  (stage_out_beat)
  );

  assign {axi.axi_st_dout_tlast, axi.axi_st_dout_tuser, axi.axi_st_dout_tdata} = stage_out_beat;

endmodule

// File: doc/intel_vvp_icon_axi_packet_arbiter.md
INTEL_VVP_ICON_AXI_PACKET_ARBITER -- requirements
Module: intel_vvp_icon_axi_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of AXI-S requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 24, tdata width per stream.
REQ-003 SHALL have parameter IS_TOKEN_INTERFACE, default 0; USER_WIDTH = 1 if set, else max(ceil(DATA_WIDTH/8), VVP_USER_KEEP_BITS).
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 arb_enable  in  1  permits new grants; does not abort an open packet.
REQ-007 axi_st_din_tvalid  in  NUM_INPUTS  per-requester valid.
REQ-008 axi_st_din_tdata  in  NUM_INPUTS*DATA_WIDTH  flattened data, input i at slice i.
REQ-009 axi_st_din_tuser  in  NUM_INPUTS*USER_WIDTH  flattened user.
REQ-010 axi_st_din_tlast  in  NUM_INPUTS  per-requester end of packet.
REQ-011 axi_st_din_tready  out  NUM_INPUTS  per-requester ready.
REQ-012 axi_st_dout_tvalid/tdata/tuser/tlast  out  1/DATA_WIDTH/USER_WIDTH/1  merged stream.
REQ-013 axi_st_dout_tready  in  1  downstream ready.
REQ-014 grant_id  out  2  index of the owning requester; valid while busy.
REQ-015 busy  out  1  high while a packet is locked.

Function
REQ-016 SHALL implement FSM: IDLE (no owner) and LOCKED (owner = grant_id).
REQ-017 IDLE->LOCKED SHALL occur at the edge where arb_enable=1 and any tvalid=1; owner = first requesting index searching upward, wrapping, from last_owner+1.
REQ-018 last_owner SHALL reset to NUM_INPUTS-1, so input 0 has priority after reset.
REQ-019 In IDLE, all axi_st_din_tready SHALL be 0 and the internal stage input valid SHALL be 0.
REQ-020 In LOCKED, only the owner's tready SHALL be asserted, equal to the output stage's input ready; all others SHALL be 0.
REQ-021 A beat SHALL transfer only on owner tvalid&&tready; non-owner data SHALL never reach dout.
REQ-022 LOCKED->IDLE SHALL occur at the edge where an owner beat with tlast=1 is accepted; last_owner <= grant_id at that edge.
REQ-023 Packet switching SHALL cost exactly one IDLE cycle; no beat of another requester SHALL be accepted in the tlast cycle.
REQ-024 arb_enable falling during LOCKED SHALL not affect the open packet; the FSM SHALL stay in IDLE afterwards until arb_enable=1.
REQ-025 Latency: first beat SHALL appear on dout 2 cycles after the IDLE cycle in which its tvalid was sampled (1 arbitration + 1 register stage), when dout_tready=1.
REQ-026 Sustained throughput inside a packet SHALL be 1 beat/cycle with dout_tready=1.
REQ-027 dout SHALL obey AXI-S: once tvalid=1, tdata/tuser/tlast SHALL stay stable until tready=1; no beat dropped or duplicated under arbitrary dout_tready.
REQ-028 Single-beat packets (tvalid with tlast on first beat) SHALL be granted and released normally.
REQ-029 Requester deasserting tvalid mid-packet SHALL keep the lock (no timeout).
REQ-030 grant_id SHALL hold last_owner value while IDLE.

Reset
REQ-031 During rst: state=IDLE, busy=0, grant_id=NUM_INPUTS-1, all din_tready=0, dout_tvalid=0; data regs need no reset.
REQ-032 rst asserted mid-packet SHALL discard the open packet and in-flight register contents; the first post-reset grant follows REQ-018.

Structure
REQ-033 FSM state enum and USER_WIDTH derivation function SHALL live in intel_vvp_icon_pkg.
REQ-034 Output register stage SHALL be one instance of intel_vvp_icon_axi_pipeline_stage fed by the owner mux; no other sub-module.

Verification
REQ-035 Inputs 0,1 each present a 4-beat packet simultaneously after reset, dout_tready=1 -> 0's 4 beats, one bubble, then 1's 4 beats; grant_id 0 then 1.
REQ-036 Input 1 streams continuous 3-beat packets, input 0 one packet mid-stream -> after current packet of 1 ends, 0 is granted next (round robin), then 1 resumes.
REQ-037 Random dout_tready 50% over 100 packets of 1..16 beats from 3 inputs -> scoreboard exact per-source order, no loss/duplication, dout stable while stalled.
REQ-038 arb_enable=0 asserted on beat 2 of a 5-beat packet -> beats 3..5 still delivered, busy falls, no new grant until arb_enable=1.
REQ-039 rst pulsed for 1 cycle on beat 3 of 6 -> dout_tvalid=0 next cycle, all tready=0, next grant goes to input 0 if requesting.
REQ-040 Single-beat packets from all inputs back-to-back -> grants cycle 0,1,2,... with one IDLE cycle between each.
